// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - framebuffer scan-out with SPRAM read/write slot arbiter
// Optional window border outline enabled by defining FB_BORDER_EN.
module fb_scanout #(
    parameter int IMG_W_LOG2 = 7,
    parameter int IMG_H_LOG2 = 7,
    parameter int X0         = 192,
    parameter int Y0         = 112,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_valid,
    input  logic [9:0]  vga_row,
    input  logic [9:0]  vga_col,
    input  logic        vga_hsync_in,
    input  logic        vga_vsync_in,
    input  logic        wr_valid,
    input  logic [13:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic [7:0]  drop_cnt,
    output logic [13:0] spram_ad,
    output logic [15:0] spram_di,
    output logic        spram_we,
    input  logic [15:0] spram_do,
    output logic [5:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] X0_V   = 10'(X0);
    localparam logic [9:0] Y0_V   = 10'(Y0);
    localparam logic [9:0] WIN_W  = 10'(2 ** (IMG_W_LOG2 + 1));
    localparam logic [9:0] WIN_H  = 10'(2 ** (IMG_H_LOG2 + 1));
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Unsigned wrap makes columns/rows left of or above the window compare as large.
    logic [9:0] dx, dy;
    logic       in_win, rd_slot, on_border;
    logic [IMG_W_LOG2-1:0] ix;
    logic [IMG_H_LOG2-1:0] iy;
    logic [13:0] rd_addr;

    assign dx      = vga_col - X0_V;
    assign dy      = vga_row - Y0_V;
    assign in_win  = vga_valid && (dx < WIN_W) && (dy < WIN_H);
    assign rd_slot = in_win && !vga_col[0];
    assign ix      = dx[IMG_W_LOG2:1];
    assign iy      = dy[IMG_H_LOG2:1];
    assign rd_addr = (14'(iy) << IMG_W_LOG2) | 14'(ix);

`ifdef FB_BORDER_EN
    localparam logic [9:0] X_LAST = WIN_W - 10'd1;
    localparam logic [9:0] Y_LAST = WIN_H - 10'd1;
    assign on_border = (dx == 10'd0) || (dx == X_LAST) || (dy == 10'd0) || (dy == Y_LAST);
`else
    assign on_border = 1'b0;
`endif

    logic [PW:0]  wr_ptr, rd_ptr;
    logic [13:0]  q_addr [FIFO_DEPTH];
    logic [15:0]  q_data [FIFO_DEPTH];
    logic         run_q, empty, full, push, pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign wr_ready = run_q && !full;
    assign push     = wr_valid && wr_ready;
    // Pop uses registered occupancy only, so a fresh push never bypasses into this slot.
    assign pop      = !rd_slot && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr[PW-1:0]] <= wr_addr;
            q_data[wr_ptr[PW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            run_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_valid && full && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    logic [1:0] win_d, rd_d, bord_d;
    logic [2:0] hs_d, vs_d;
    logic [1:0] grey_hi, pix;
    logic       unused_do;

    assign unused_do = ^{spram_do[15:8], spram_do[5:0]};
    assign pix       = rd_d[1] ? spram_do[7:6] : grey_hi;
    assign hsync_out = hs_d[2];
    assign vsync_out = vs_d[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spram_we <= 1'b0;
            spram_ad <= 14'd0;
            spram_di <= 16'd0;
            win_d    <= 2'b00;
            rd_d     <= 2'b00;
            bord_d   <= 2'b00;
            hs_d     <= 3'b000;
            vs_d     <= 3'b000;
            grey_hi  <= 2'b00;
            rgb      <= 6'd0;
        end else begin
            if (rd_slot) begin
                spram_we <= 1'b0;
                spram_ad <= rd_addr;
            end else if (pop) begin
                spram_we <= 1'b1;
                spram_ad <= q_addr[rd_ptr[PW-1:0]];
                spram_di <= q_data[rd_ptr[PW-1:0]];
            end else begin
                spram_we <= 1'b0;
            end
            win_d  <= {win_d[0], in_win};
            rd_d   <= {rd_d[0], rd_slot};
            bord_d <= {bord_d[0], on_border};
            hs_d   <= {hs_d[1:0], vga_hsync_in};
            vs_d   <= {vs_d[1:0], vga_vsync_in};
            // Odd column of each pair reuses the grey captured on the preceding read.
            if (rd_d[1])
                grey_hi <= spram_do[7:6];
            if (!win_d[1])
                rgb <= 6'd0;
            else if (bord_d[1])
                rgb <= 6'b111111;
            else
                rgb <= {pix, pix, pix};
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - directed self-checking bench for fb_scanout
module tb_fb_scanout;
    localparam int X0 = 192;
    localparam int Y0 = 112;

    logic        clk, rst;
    logic        vga_valid, vga_hsync_in, vga_vsync_in;
    logic [9:0]  vga_row, vga_col;
    logic        wr_valid, wr_ready;
    logic [13:0] wr_addr, spram_ad;
    logic [15:0] wr_data, spram_di, spram_do;
    logic [7:0]  drop_cnt;
    logic        spram_we;
    logic [5:0]  rgb;
    logic        hsync_out, vsync_out;

    logic [15:0] mem [16384];
    logic        fill_req;
    logic [15:0] fill_val;
    logic [5:0]  obs [64];
    int          tests = 0;
    int          fails = 0;
    int          bad_we;

    fb_scanout dut (
        .clk(clk), .rst(rst),
        .vga_valid(vga_valid), .vga_row(vga_row), .vga_col(vga_col),
        .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .drop_cnt(drop_cnt),
        .spram_ad(spram_ad), .spram_di(spram_di), .spram_we(spram_we),
        .spram_do(spram_do), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // SPRAM model: one-clock registered read.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < 16384; k++)
                mem[k] <= fill_val;
        end else if (spram_we) begin
            mem[spram_ad] <= spram_di;
        end
        spram_do <= mem[spram_ad];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        fill_val = v;
        fill_req = 1'b1;
        step;
        fill_req = 1'b0;
        step;
    endtask

    function automatic logic [5:0] exp_pix(input int r, input int c);
        int ix, iy;
        logic [15:0] w;
        if (r < Y0 || r >= Y0 + 256 || c < X0 || c >= X0 + 256)
            return 6'd0;
`ifdef FB_BORDER_EN
        if (r == Y0 || r == Y0 + 255 || c == X0 || c == X0 + 255)
            return 6'b111111;
`endif
        ix = (c - X0) / 2;
        iy = (r - Y0) / 2;
        w = mem[iy * 128 + ix];
        return {w[7:6], w[7:6], w[7:6]};
    endfunction

    function automatic logic [15:0] wdata_of(input int k);
        return {8'h5A, 8'(k * 16 + 3)};
    endfunction

    task automatic scan(input int row, input int col0, input int n,
                        input bit do_wr, input logic [13:0] wbase);
        logic hs_h [64];
        logic vs_h [64];
        bad_we = 0;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                vga_valid = 1'b1;
                vga_row = 10'(row);
                vga_col = 10'(col0 + i);
                vga_hsync_in = (i % 3 == 0);
                vga_vsync_in = (i % 4 == 1);
            end else begin
                vga_valid = 1'b0;
                vga_hsync_in = 1'b0;
                vga_vsync_in = 1'b0;
            end
            hs_h[i] = vga_hsync_in;
            vs_h[i] = vga_vsync_in;
            if (do_wr && i < n && i % 2 == 0) begin
                wr_valid = 1'b1;
                wr_addr = wbase + 14'(i / 2);
                wr_data = wdata_of(i / 2);
            end else begin
                wr_valid = 1'b0;
            end
            step;
            if (spram_we && i < n && ((col0 + i) % 2 == 0))
                bad_we++;
            if (i >= 2) begin
                obs[i-2] = rgb;
                tests += 2;
                if (hsync_out !== hs_h[i-2]) begin
                    fails++;
                    $display("FAIL hsync_delay row %0d col %0d: got %b want %b", row, col0 + i - 2, hsync_out, hs_h[i-2]);
                end
                if (vsync_out !== vs_h[i-2]) begin
                    fails++;
                    $display("FAIL vsync_delay row %0d col %0d: got %b want %b", row, col0 + i - 2, vsync_out, vs_h[i-2]);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_scan(input string name, input int row, input int col0, input int n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if (obs[k] !== exp_pix(row, col0 + k)) begin
                fails++;
                $display("FAIL %s row %0d col %0d: rgb %b want %b", name, row, col0 + k, obs[k], exp_pix(row, col0 + k));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vga_hsync_in = 1'b1;
        vga_vsync_in = 1'b1;
        step;
        step;
        tests += 8;
        if (rgb !== 6'd0) begin fails++; $display("FAIL reset_rgb: got %b want 0", rgb); end
        if (hsync_out !== 1'b0) begin fails++; $display("FAIL reset_hsync: got %b want 0", hsync_out); end
        if (vsync_out !== 1'b0) begin fails++; $display("FAIL reset_vsync: got %b want 0", vsync_out); end
        if (spram_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", spram_we); end
        if (spram_ad !== 14'd0) begin fails++; $display("FAIL reset_ad: got %h want 0", spram_ad); end
        if (spram_di !== 16'd0) begin fails++; $display("FAIL reset_di: got %h want 0", spram_di); end
        if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
        vga_hsync_in = 1'b0;
        vga_vsync_in = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (wr_ready !== 1'b0) begin fails++; $display("FAIL release_ready_early: got %b want 0", wr_ready); end
        step;
        tests++;
        if (wr_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_outside_write;
        fill(16'h0000);
        tests++;
        if (wr_ready !== 1'b1) begin fails++; $display("FAIL outside_ready: got %b want 1", wr_ready); end
        wr_valid = 1'b1;
        wr_addr = 14'h0000;
        wr_data = 16'h00C0;
        step;
        wr_valid = 1'b0;
        repeat (3) step;
        tests++;
        if (mem[0] !== 16'h00C0) begin fails++; $display("FAIL outside_mem: got %h want 00c0", mem[0]); end
        scan(Y0, X0, 4, 1'b0, 14'd0);
        tests += 2;
        if (obs[0] !== 6'b111111) begin fails++; $display("FAIL outside_col0: rgb %b want 111111", obs[0]); end
        if (obs[1] !== 6'b111111) begin fails++; $display("FAIL outside_col1: rgb %b want 111111", obs[1]); end
        check_scan("outside_rest", Y0, X0, 4);
    endtask

    task automatic test_interleave;
        logic [13:0] wbase;
        wbase = 14'(100 * 128);
        scan(Y0 + 10, X0, 32, 1'b1, wbase);
        tests++;
        if (bad_we !== 0) begin fails++; $display("FAIL interleave_even_we: %0d writes on read slots, want 0", bad_we); end
        check_scan("interleave_line", Y0 + 10, X0, 32);
        repeat (4) step;
        tests++;
        if (drop_cnt !== 8'd0) begin fails++; $display("FAIL interleave_drop: got %0d want 0", drop_cnt); end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (mem[wbase + 14'(k)] !== wdata_of(k)) begin
                fails++;
                $display("FAIL interleave_word %0d: got %h want %h", k, mem[wbase + 14'(k)], wdata_of(k));
            end
        end
        scan(Y0 + 200, X0, 32, 1'b0, 14'd0);
        check_scan("interleave_readback", Y0 + 200, X0, 32);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 20; i++) begin
            vga_valid = 1'b1;
            vga_row = 10'(Y0 + 20);
            vga_col = 10'(X0 + i);
            wr_valid = 1'b1;
            wr_addr = 14'h3E00 + 14'(i);
            wr_data = 16'(i);
            if (i == 7) begin
                tests++;
                if (wr_ready !== 1'b0) begin fails++; $display("FAIL overflow_ready_low: got %b want 0", wr_ready); end
            end
            if (i == 8) begin
                tests++;
                if (wr_ready !== 1'b1) begin fails++; $display("FAIL overflow_ready_high: got %b want 1", wr_ready); end
            end
            step;
        end
        tests++;
        if (drop_cnt !== 8'd7) begin fails++; $display("FAIL overflow_drop: got %0d want 7", drop_cnt); end
        vga_col = 10'(X0);
        repeat (10) step;
        tests++;
        if (drop_cnt !== 8'd16) begin fails++; $display("FAIL overflow_drop_full: got %0d want 16", drop_cnt); end
        repeat (300) step;
        tests++;
        if (drop_cnt !== 8'd255) begin fails++; $display("FAIL overflow_saturate: got %0d want 255", drop_cnt); end
        wr_valid = 1'b0;
        vga_valid = 1'b0;
        repeat (8) step;
    endtask

    task automatic test_window_edges;
        fill(16'h0040);
        scan(Y0 + 10, 190, 4, 1'b0, 14'd0);
        check_scan("edge_left", Y0 + 10, 190, 4);
        scan(Y0 + 10, 446, 4, 1'b0, 14'd0);
        check_scan("edge_right", Y0 + 10, 446, 4);
        scan(111, 200, 2, 1'b0, 14'd0);
        check_scan("edge_row111", 111, 200, 2);
        scan(112, 200, 2, 1'b0, 14'd0);
        check_scan("edge_row112", 112, 200, 2);
        scan(367, 200, 2, 1'b0, 14'd0);
        check_scan("edge_row367", 367, 200, 2);
        scan(368, 200, 2, 1'b0, 14'd0);
        check_scan("edge_row368", 368, 200, 2);
    endtask

    task automatic test_reset_mid;
        int we_seen;
        vga_valid = 1'b1;
        vga_row = 10'(Y0 + 10);
        vga_col = 10'(X0 + 2);
        vga_hsync_in = 1'b1;
        vga_vsync_in = 1'b1;
        repeat (4) step;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_addr = 14'h0111 + 14'(k);
            wr_data = 16'hBEE0 + 16'(k);
            step;
        end
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests += 8;
        if (rgb !== 6'd0) begin fails++; $display("FAIL midrst_rgb: got %b want 0", rgb); end
        if (hsync_out !== 1'b0) begin fails++; $display("FAIL midrst_hsync: got %b want 0", hsync_out); end
        if (vsync_out !== 1'b0) begin fails++; $display("FAIL midrst_vsync: got %b want 0", vsync_out); end
        if (spram_we !== 1'b0) begin fails++; $display("FAIL midrst_we: got %b want 0", spram_we); end
        if (spram_ad !== 14'd0) begin fails++; $display("FAIL midrst_ad: got %h want 0", spram_ad); end
        if (spram_di !== 16'd0) begin fails++; $display("FAIL midrst_di: got %h want 0", spram_di); end
        if (wr_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b want 0", wr_ready); end
        if (drop_cnt !== 8'd0) begin fails++; $display("FAIL midrst_drop: got %0d want 0", drop_cnt); end
        step;
        step;
        rst = 1'b0;
        we_seen = 0;
        step;
        we_seen += int'(spram_we);
        tests += 2;
        if (wr_ready !== 1'b1) begin fails++; $display("FAIL midrst_release_ready: got %b want 1", wr_ready); end
        if (rgb !== 6'd0) begin fails++; $display("FAIL midrst_refill1: rgb %b want 0", rgb); end
        step;
        we_seen += int'(spram_we);
        tests++;
        if (rgb !== 6'd0) begin fails++; $display("FAIL midrst_refill2: rgb %b want 0", rgb); end
        step;
        we_seen += int'(spram_we);
        tests++;
        if (rgb !== exp_pix(Y0 + 10, X0 + 2)) begin fails++; $display("FAIL midrst_resume: rgb %b want %b", rgb, exp_pix(Y0 + 10, X0 + 2)); end
        vga_valid = 1'b0;
        vga_hsync_in = 1'b0;
        vga_vsync_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step;
            we_seen += int'(spram_we);
        end
        tests += 3;
        if (we_seen !== 0) begin fails++; $display("FAIL midrst_discard: %0d writes seen, want 0", we_seen); end
        if (mem[14'h0111] !== 16'h0040) begin fails++; $display("FAIL midrst_mem: got %h want 0040", mem[14'h0111]); end
        if (drop_cnt !== 8'd0) begin fails++; $display("FAIL midrst_drop_after: got %0d want 0", drop_cnt); end
    endtask

`ifdef FB_BORDER_EN
    task automatic test_border;
        fill(16'h0000);
        scan(Y0, X0 + 50, 2, 1'b0, 14'd0);
        tests += 2;
        if (obs[0] !== 6'b111111) begin fails++; $display("FAIL border_top0: rgb %b want 111111", obs[0]); end
        if (obs[1] !== 6'b111111) begin fails++; $display("FAIL border_top1: rgb %b want 111111", obs[1]); end
        scan(Y0 + 30, X0 + 254, 2, 1'b0, 14'd0);
        tests += 2;
        if (obs[0] !== 6'd0) begin fails++; $display("FAIL border_inner_right: rgb %b want 0", obs[0]); end
        if (obs[1] !== 6'b111111) begin fails++; $display("FAIL border_right: rgb %b want 111111", obs[1]); end
        scan(Y0 + 30, X0 + 50, 2, 1'b0, 14'd0);
        tests += 2;
        if (obs[0] !== 6'd0) begin fails++; $display("FAIL border_interior0: rgb %b want 0", obs[0]); end
        if (obs[1] !== 6'd0) begin fails++; $display("FAIL border_interior1: rgb %b want 0", obs[1]); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        vga_valid = 1'b0;
        vga_row = 10'd0;
        vga_col = 10'd0;
        vga_hsync_in = 1'b0;
        vga_vsync_in = 1'b0;
        wr_valid = 1'b0;
        wr_addr = 14'd0;
        wr_data = 16'd0;
        fill_req = 1'b0;
        fill_val = 16'd0;
        bad_we = 0;
        test_reset;
        test_outside_write;
        test_interleave;
        test_overflow;
        test_window_edges;
        test_reset_mid;
`ifdef FB_BORDER_EN
        test_border;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer scan-out and SPRAM arbiter. It owns the single SP256K port and reads greyscale pixels back out for the VGA path. Camera-side writes are queued in a small FIFO and interleaved into idle SPRAM slots. A 128x128 image is shown 2x-scaled in a centred 256x256 window; everything else on screen is black. It sits between the camera capture logic, the `vga` timing generator, and the RGB/HSYNC/VSYNC pins.

## Interface
Parameters:
- `IMG_W_LOG2`, default 7: log2 of image width in pixels.
- `IMG_H_LOG2`, default 7: log2 of image height in pixels. `IMG_W_LOG2 + IMG_H_LOG2` must be 14 or less.
- `X0`, default 192: first screen column of the window.
- `Y0`, default 112: first screen row of the window.
- `FIFO_DEPTH`, default 4: write FIFO entries. Must be a power of 2.

Ports (clock and reset first):
- `clk`  in  1  25 MHz system clock. The block uses this one clock only.
- `rst`  in  1  asynchronous, active-high reset.
- `vga_valid`  in  1  active-video flag from `vga`.
- `vga_row`  in  10  current scan row.
- `vga_col`  in  10  current scan column.
- `vga_hsync_in`  in  1  HSYNC from `vga`.
- `vga_vsync_in`  in  1  VSYNC from `vga`.
- `wr_valid`  in  1  write request from the camera side.
- `wr_addr`  in  14  SPRAM word address for the write.
- `wr_data`  in  16  write data; the low byte holds greyscale.
- `wr_ready`  out  1  the FIFO can accept a write.
- `drop_cnt`  out  8  saturating count of writes dropped while the FIFO was full.
- `spram_ad`  out  14  SPRAM address.
- `spram_di`  out  16  SPRAM write data.
- `spram_we`  out  1  SPRAM write enable.
- `spram_do`  in  16  SPRAM read data. It is valid one clock after `spram_ad`.
- `rgb`  out  6  pixel colour, formatted {R1:0, G1:0, B1:0}.
- `hsync_out`  out  1  HSYNC delayed to align with `rgb`.
- `vsync_out`  out  1  VSYNC delayed to align with `rgb`.

## Operation
- Window: `in_win` = `vga_valid` AND `X0` ≤ col < `X0+2^(IMG_W_LOG2+1)` AND `Y0` ≤ row < `Y0+2^(IMG_H_LOG2+1)`.
- Image coordinates: ix = (col−`X0`)>>1 and iy = (row−`Y0`)>>1, using 10-bit unsigned subtraction.
- Read address: the concatenation {iy, ix}, zero-extended to 14 bits.
- Slot assignment, decided each cycle from that cycle's inputs:
  - READ when `in_win` and col[0]==0. Drive `spram_we`=0 and `spram_ad`=read address.
  - WRITE in every other cycle where the FIFO is non-empty. Drive `spram_we`=1, `spram_ad`/`spram_di` = FIFO head, and pop the FIFO.
  - IDLE otherwise. Drive `spram_we`=0 and hold `spram_ad`.
- `spram_ad`, `spram_di` and `spram_we` are registered outputs.
- Write bandwidth: inside the window the block sustains at least one write per 2 clocks; outside the window, one per clock.
- FIFO behaviour:
  - `wr_ready` = !full.
  - A push happens on `wr_valid && wr_ready`.
  - `wr_valid` while full drops the write and increments `drop_cnt`, which saturates at 255.
  - A simultaneous push and pop when the FIFO is non-full is allowed; occupancy stays unchanged.
  - A pop and a push in the same cycle on an empty FIFO do not bypass: the new entry is written on a later slot.
- Pixel hold: the grey register captures `spram_do[7:0]` only on cycles where the returned data belongs to a READ slot. The odd column of each pair reuses that value, which gives the 2x horizontal replication. Vertical replication comes from iy repeating.
- Colour mapping: g = grey[7:6]; `rgb` = {g, g, g} if the pipelined `in_win` is set, otherwise 6'b000000.

## Timing
- Pipeline: inputs at cycle N → `spram_ad` at N+1 → `spram_do` at N+2 → `rgb` registered at N+3.
- `hsync_out` and `vsync_out` are the inputs delayed by exactly 3 clocks, so they stay aligned with `rgb`.
- `in_win` and the slot type are pipelined alongside the data.
- Write-to-visible: a write pushed at cycle M reaches SPRAM no later than M+1+2·(occupancy) inside the window.
- Reset values:
  - `rgb`=0, `hsync_out`=0, `vsync_out`=0.
  - `spram_we`=0, `spram_ad`=0, `spram_di`=0.
  - `drop_cnt`=0, FIFO empty, `wr_ready`=0.
- Reset release: `wr_ready` goes to 1 on the first clock after `rst` deasserts. The pipeline refills, so the first 3 `rgb` values after release are 0.
- Reset mid-frame: all queued writes are discarded and are not counted in `drop_cnt`. Scan-out resumes with the next sampled col and row; no frame resync is needed.
- Window boundaries: col `X0−1` is black; col `X0` reads ix=0; col `X0+255` shows ix=127; col `X0+256` is black.

## Configuration
- `FB_BORDER_EN` defined: the outermost screen pixels of the window are forced to `rgb`=6'b111111. These are col `X0`, col `X0+255`, row `Y0` and row `Y0+255`. Slot scheduling is unchanged.
- `FB_BORDER_EN` undefined: there is no border, and every window pixel comes from SPRAM.

## Test plan
- Outside-window write: push addr 0x0000 data 0x00C0 during blanking, then scan row `Y0`, col `X0`. Expect `rgb`=6'b111111 on both col `X0` and col `X0+1`, three clocks after each.
- In-window interleave: stream 1 write per 2 clocks during an active window line. Expect `spram_we` only on odd-col cycles, `drop_cnt`=0, and every word later read back correctly.
- FIFO overflow: hold `wr_valid`=1 with a new value every clock through 20 window cycles. Expect `wr_ready` to drop after the FIFO fills, `drop_cnt` to count only the refused beats, and saturation at 255 after 300 refused beats.
- Window edges: fill the image with grey 0x40. Expect `rgb`=0 at col 191 and 448 and at row 111 and 368, and 6'b010101 at col 192, col 447, row 112 and row 367. Sync outputs are delayed exactly 3 clocks.
- Reset mid-operation: assert `rst` with 3 entries queued and mid-line. Expect all outputs 0 immediately, `wr_ready`=1 one clock after release, no SPRAM write of the discarded entries, and `drop_cnt`=0.
- With `FB_BORDER_EN`: an all-zero image gives `rgb`=6'b111111 at (row `Y0`, any window col) and (col `X0+255`, any window row), and 0 in the interior.
